// File: rtl/uram_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module      : uram_fifo_reader
// Description : Credit-based reader for a fixed-latency upstream FIFO
//               (uram_fifo). Issues reads only when the output buffer has
//               room for every word already in flight, captures returning
//               words into a small circular buffer and presents them as a
//               valid/ready stream with registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module uram_fifo_reader #(
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 2,
  parameter int BUF_DEPTH    = READ_LATENCY + 2
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]            fifo_rd_data,
  input  logic                             fifo_rd_busy,
  output logic                             m_valid,
  output logic [DATA_WIDTH-1:0]            m_data,
  input  logic                             m_ready,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   buf_count
);

  localparam int c_cnt_w = $clog2(BUF_DEPTH + 1);
  localparam int c_ptr_w = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int c_sum_w = c_cnt_w + 1;
  localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(BUF_DEPTH - 1);

  // Reject parameter sets the credit scheme cannot honour
  if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_bad_latency
    $error("uram_fifo_reader: READ_LATENCY must be in 1..8");
  end
  if (BUF_DEPTH < READ_LATENCY + 1) begin : g_bad_depth
    $error("uram_fifo_reader: BUF_DEPTH must be at least READ_LATENCY+1");
  end

  // In-flight tracking: bit i set means a read accepted i+1 edges ago
  logic [READ_LATENCY-1:0] r_sr;
  logic [READ_LATENCY-1:0] w_sr_next;

  // Circular output buffer and its bookkeeping
  logic [DATA_WIDTH-1:0]   r_mem [BUF_DEPTH];
  logic [c_ptr_w-1:0]      r_head;
  logic [c_ptr_w-1:0]      r_tail;
  logic [c_cnt_w-1:0]      r_count;

  // Registered stream outputs
  logic                    r_valid;
  logic [DATA_WIDTH-1:0]   r_data;

  logic [c_cnt_w-1:0]      w_inflight;
  logic                    w_credit_ok;
  logic                    w_accept;
  logic                    w_push;
  logic                    w_pop;
  logic [c_cnt_w-1:0]      w_count_next;
  logic [c_ptr_w-1:0]      w_head_next;
  logic [c_ptr_w-1:0]      w_tail_next;
  logic                    w_empty_after_pop;
  logic [DATA_WIDTH-1:0]   w_head_data;

  // Modulo-BUF_DEPTH pointer increment; works for non power-of-two depths
  function automatic logic [c_ptr_w-1:0] f_ptr_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_last_ptr) ? '0 : p + 1'b1;
  endfunction

  // Count reads still travelling through the upstream read pipeline
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      w_inflight = w_inflight + c_cnt_w'(r_sr[i]);
    end
  end

  // A read is only issued if every outstanding word plus this one fits
  assign w_credit_ok = ({1'b0, r_count} + {1'b0, w_inflight}) < c_sum_w'(BUF_DEPTH);
  assign fifo_rd_en  = !rst && !fifo_rd_busy && w_credit_ok;
  assign w_accept    = fifo_rd_en;

  // Returning word lands exactly when the oldest in-flight stage is set
  assign w_push = r_sr[READ_LATENCY-1];
  assign w_pop  = r_valid && m_ready;

  // Next-state computation for shift register, pointers, count and head word
  always_comb begin
    w_sr_next         = r_sr << 1;
    w_sr_next[0]      = w_accept;
    w_count_next      = r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    w_head_next       = w_pop  ? f_ptr_inc(r_head) : r_head;
    w_tail_next       = w_push ? f_ptr_inc(r_tail) : r_tail;
    // When the buffer drains to nothing this edge, an arriving word becomes
    // the new head directly, bypassing the storage array.
    w_empty_after_pop = (r_count == c_cnt_w'(w_pop));
    if (w_push && w_empty_after_pop) begin
      w_head_data = fifo_rd_data;
    end else begin
      w_head_data = r_mem[w_head_next];
    end
  end

  // Control state and registered stream outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr    <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_sr    <= w_sr_next;
      r_head  <= w_head_next;
      r_tail  <= w_tail_next;
      r_count <= w_count_next;
      r_valid <= (w_count_next != '0);
      r_data  <= (w_count_next != '0) ? w_head_data : '0;
    end
  end

  // Buffer storage write; the credit rule guarantees the tail slot is free
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_tail] <= fifo_rd_data;
    end
  end

  assign m_valid   = r_valid;
  assign m_data    = r_data;
  assign buf_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uram_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_uram_fifo_reader
// Description : Directed self-checking bench for uram_fifo_reader with an
//               upstream fixed-latency FIFO model and an output scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uram_fifo_reader;

  localparam int DW = 16;
  localparam int RL = 2;
  localparam int BD = 4;
  localparam int CW = $clog2(BD + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_busy = 1'b0;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b0;
  logic [CW-1:0] buf_count;

  uram_fifo_reader #(
    .DATA_WIDTH  (DW),
    .READ_LATENCY(RL),
    .BUF_DEPTH   (BD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_busy(fifo_rd_busy),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_ready     (m_ready),
    .buf_count   (buf_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Upstream FIFO contents and its read pipeline
  logic [DW-1:0] upq [$];
  logic [DW-1:0] pd  [RL];
  bit            pv  [RL];
  // Scoreboard of words that must appear on the stream, oldest first
  logic [DW-1:0] expq [$];
  // Expected output-buffer occupancy
  int            cnt = 0;

  int busy_mode    = 0;   // 0: busy when empty, 1: forced busy, 2: forced free
  bit toggle_ready = 0;
  int cycle_no     = 0;
  int first_acc    = -1;
  int first_val    = -1;
  int cur_run      = 0;
  int max_run      = 0;
  int n_acc        = 0;
  int n_del        = 0;
  int max_cnt      = 0;
  int gaps         = 0;
  bit gap_watch    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive_up();
    if (busy_mode == 1)      fifo_rd_busy = 1'b1;
    else if (busy_mode == 2) fifo_rd_busy = 1'b0;
    else                     fifo_rd_busy = (upq.size() == 0);
    fifo_rd_data = pv[RL-1] ? pd[RL-1] : 16'hDEAD;
  endtask

  task automatic cyc();
    int            infl;
    bit            acc, pop, pop_m, cap, rs;
    logic [DW-1:0] w;
    if (toggle_ready) m_ready = ~m_ready;
    drive_up();
    @(negedge clk);
    infl = 0;
    for (int i = 0; i < RL; i++) infl += int'(pv[i]);
    check("fifo_rd_en", {31'b0, fifo_rd_en}, {31'b0, (!rst && !fifo_rd_busy && (cnt + infl < BD))});
    check("buf_count", 32'(buf_count), 32'(cnt));
    check("m_valid", {31'b0, m_valid}, {31'b0, (cnt != 0)});
    if (m_valid) begin
      if (expq.size() == 0) check("m_valid_no_word", {31'b0, m_valid}, 32'd0);
      else                  check("m_data", 32'(m_data), 32'(expq[0]));
    end
    acc   = fifo_rd_en && !fifo_rd_busy;
    pop   = m_valid && m_ready;
    pop_m = (cnt != 0) && m_ready;
    cap   = pv[RL-1];
    rs    = rst;
    if (acc && first_acc < 0) first_acc = cycle_no;
    if (m_valid && first_val < 0) first_val = cycle_no;
    if (m_valid) cur_run++; else cur_run = 0;
    if (cur_run > max_run) max_run = cur_run;
    if (int'(buf_count) > max_cnt) max_cnt = int'(buf_count);
    if (gap_watch && !m_valid && expq.size() != 0) gaps++;
    if (pop && expq.size() != 0) begin
      void'(expq.pop_front());
      n_del++;
    end
    if (acc) n_acc++;
    @(posedge clk);
    #1;
    cycle_no++;
    if (rs) begin
      cnt = 0;
      upq.delete();
      expq.delete();
      for (int i = 0; i < RL; i++) pv[i] = 1'b0;
    end else begin
      cnt = cnt + int'(cap) - int'(pop_m);
      for (int i = RL - 1; i > 0; i--) begin
        pv[i] = pv[i-1];
        pd[i] = pd[i-1];
      end
      pv[0] = acc;
      pd[0] = '0;
      if (acc) begin
        if (upq.size() == 0) begin
          check("read_from_empty", {31'b0, acc}, 32'd0);
        end else begin
          w = upq.pop_front();
          pd[0] = w;
          expq.push_back(w);
        end
      end
    end
  endtask

  task automatic drain(input int max_cyc);
    int k = 0;
    while ((upq.size() != 0 || expq.size() != 0) && k < max_cyc) begin
      cyc();
      k++;
    end
    check("drain_done", 32'(expq.size() + upq.size()), 32'd0);
  endtask

  task automatic load(input int base, input int n);
    for (int i = 0; i < n; i++) upq.push_back(DW'(base + i));
  endtask

  initial begin
    int k;
    for (int i = 0; i < RL; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end

    // Reset held with upstream not busy: everything stays idle and cleared
    rst = 1'b1;
    busy_mode = 2;
    m_ready = 1'b0;
    @(posedge clk);
    #1;
    repeat (5) begin
      cyc();
      check("rst_rd_en", {31'b0, fifo_rd_en}, 32'd0);
      check("rst_m_valid", {31'b0, m_valid}, 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      check("rst_buf_count", 32'(buf_count), 32'd0);
    end
    rst = 1'b0;
    busy_mode = 0;

    // Full-rate stream of 18 words
    load(16'h0001, 18);
    m_ready = 1'b1;
    first_acc = -1; first_val = -1; cur_run = 0; max_run = 0; n_del = 0;
    drain(100);
    check("stream_count", 32'(n_del), 32'd18);
    check("stream_latency", 32'(first_val - first_acc), 32'd3);
    check("stream_run", 32'(max_run), 32'd18);

    // Backpressure: buffer fills to BUF_DEPTH and holds the head word
    load(16'h0001, 10);
    m_ready = 1'b0;
    n_acc = 0;
    repeat (10) cyc();
    check("bp_reads", 32'(n_acc), 32'd4);
    check("bp_buf_count", 32'(buf_count), 32'd4);
    check("bp_head", 32'(m_data), 32'h0001);
    m_ready = 1'b1;
    n_del = 0; gaps = 0; gap_watch = 1'b1;
    drain(100);
    gap_watch = 1'b0;
    check("bp_count", 32'(n_del), 32'd10);
    check("bp_gaps", 32'(gaps), 32'd0);

    // Upstream busy: no reads, no output, then the queued words flow
    busy_mode = 1;
    load(16'h0030, 8);
    repeat (10) begin
      cyc();
      check("busy_rd_en", {31'b0, fifo_rd_en}, 32'd0);
      check("busy_m_valid", {31'b0, m_valid}, 32'd0);
    end
    busy_mode = 0;
    n_del = 0;
    drain(100);
    check("busy_count", 32'(n_del), 32'd8);

    // Alternating downstream ready
    load(16'h0100, 16);
    toggle_ready = 1'b1;
    max_cnt = 0; n_del = 0;
    drain(200);
    toggle_ready = 1'b0;
    m_ready = 1'b1;
    check("toggle_count", 32'(n_del), 32'd16);
    check("toggle_max_le_depth", {31'b0, (max_cnt <= BD)}, 32'd1);

    // Reset mid-stream with words buffered and in flight
    m_ready = 1'b0;
    load(16'h0050, 8);
    k = 0;
    while (cnt != 3 && k < 20) begin
      cyc();
      k++;
    end
    check("mid_buf_count", 32'(buf_count), 32'd3);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    busy_mode = 1;
    check("mid_rst_m_valid", {31'b0, m_valid}, 32'd0);
    check("mid_rst_buf_count", 32'(buf_count), 32'd0);
    repeat (4) cyc();
    check("mid_no_capture", 32'(buf_count), 32'd0);
    busy_mode = 0;
    load(16'h0060, 4);
    m_ready = 1'b1;
    n_del = 0;
    drain(100);
    check("mid_recover_count", 32'(n_del), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
